// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared types and helpers for the streaming popcount block
package popcount_pkg;

    // Bits needed to hold a count of 0..n
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_t;

endpackage

// File: rtl/popcount_tree.sv
// rtl/popcount_tree.sv - combinational ones counter built as a recursive halving adder tree
module popcount_tree
    import popcount_pkg::*;
#(
    parameter int WIDTH = 15,
    localparam int CW = cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] in_bits,
    output logic [CW-1:0]    count
);

    generate
        if (WIDTH == 1) begin : gen_leaf
            assign count = in_bits;
        end else begin : gen_split
            localparam int LO  = WIDTH / 2;
            localparam int HI  = WIDTH - LO;
            localparam int LCW = cnt_w(LO);
            localparam int HCW = cnt_w(HI);

            logic [LCW-1:0] lo_cnt;
            logic [HCW-1:0] hi_cnt;

            popcount_tree #(.WIDTH(LO)) u_lo (
                .in_bits (in_bits[LO-1:0]),
                .count   (lo_cnt)
            );

            popcount_tree #(.WIDTH(HI)) u_hi (
                .in_bits (in_bits[WIDTH-1:LO]),
                .count   (hi_cnt)
            );

            // Both halves together never exceed WIDTH, so CW bits always suffice
            assign count = CW'(lo_cnt) + CW'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/popcount_stream.sv
// rtl/popcount_stream.sv - two-stage pipelined popcount with saturating per-frame total
module popcount_stream
    import popcount_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int ACC_W = 16,
    localparam int CW = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    word_count,
    output logic [ACC_W-1:0] frame_total,
    output logic             frame_done,
    output logic             overflow
);

    localparam int SW = ACC_W + 1;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s1_last_q, s1_last_d;

    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    word_count_q, word_count_d;
    logic [ACC_W-1:0] frame_total_q, frame_total_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;
    frame_state_t     state_q, state_d;

    logic             adv2;
    logic             accept;
    logic             load2;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    base;
    logic [SW-1:0]    sum;

    // S2 can take a new beat whenever it is empty or being drained this cycle
    assign adv2      = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || adv2;
    assign accept    = in_valid && in_ready;
    assign load2     = adv2 && s1_valid_q;

    popcount_tree #(.WIDTH(WIDTH)) u_tree (
        .in_bits (s1_data_q),
        .count   (cnt)
    );

    // S1 capture: refill on accept, empty when S2 takes the beat without a refill
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_last_d  = in_last;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 load, frame accumulation with saturation, and frame FSM next state
    always_comb begin
        out_valid_d   = out_valid_q;
        word_count_d  = word_count_q;
        frame_total_d = frame_total_q;
        frame_done_d  = frame_done_q;
        overflow_d    = overflow_q;
        state_d       = state_q;
        base          = (state_q == ACTIVE) ? {1'b0, frame_total_q} : '0;
        sum           = base + SW'(cnt);
        if (adv2) begin
            out_valid_d = s1_valid_q;
        end
        if (load2) begin
            word_count_d  = cnt;
            frame_total_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            overflow_d    = sum[ACC_W] || ((state_q == ACTIVE) && overflow_q);
            frame_done_d  = s1_last_q;
            state_d       = s1_last_q ? IDLE : ACTIVE;
        end
    end

    // Pipeline and FSM registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_last_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            word_count_q  <= '0;
            frame_total_q <= '0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            state_q       <= IDLE;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_last_q     <= s1_last_d;
            out_valid_q   <= out_valid_d;
            word_count_q  <= word_count_d;
            frame_total_q <= frame_total_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign word_count  = word_count_q;
    assign frame_total = frame_total_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;

endmodule
